timer_counter_unit: RTL and testbench

//  Parametrised timer/counter. Successor to the 8-bit edge counter: one clock, selectable count source
//  (internal prescaled tick or synchronised external event, rising/falling/both), wrap or saturate.

---
 rtl/timer_counter_unit.sv | 136 +++++++++++++
 tb/tb_timer_counter_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter_unit.sv
// timer_counter_unit: parametrised timer/counter with selectable count source,
// wrap/saturate, two compare channels with optional clear-on-compare, parallel
// load and sticky write-1-to-clear status flags.
module timer_counter_unit #(
    parameter int unsigned BIT_WIDTH = 8
) (
    input  logic                 CounterClock,
    input  logic                 CounterReset,
    input  logic                 CountEnable,
    input  logic                 CountTick,
    input  logic                 ExtEvent,
    input  logic [1:0]           CounterEdge,
    input  logic                 WrapMode,
    input  logic [1:0]           ClearMode,
    input  logic                 CounterClear,
    input  logic                 LoadEn,
    input  logic [BIT_WIDTH-1:0] LoadValue,
    input  logic [BIT_WIDTH-1:0] CompareA,
    input  logic [BIT_WIDTH-1:0] CompareB,
    input  logic [2:0]           FlagClear,
    output logic [BIT_WIDTH-1:0] TCNT,
    output logic                 Overflow,
    output logic                 MatchA,
    output logic                 MatchB,
    output logic                 EventPulse
);

    // Count source selection
    localparam logic [1:0] SRC_TICK = 2'b00;
    localparam logic [1:0] SRC_RISE = 2'b01;
    localparam logic [1:0] SRC_FALL = 2'b10;
    localparam logic [1:0] SRC_BOTH = 2'b11;

    // Clear-on-compare selection (11 behaves as free-run)
    localparam logic [1:0] CTC_A = 2'b01;
    localparam logic [1:0] CTC_B = 2'b10;

    localparam logic [BIT_WIDTH-1:0] MAX_COUNT = '1;

    logic                 ext_q;
    logic                 rise;
    logic                 fall;
    logic                 src;
    logic                 inc;
    logic                 count_ok;
    logic                 at_max;
    logic                 hit_a;
    logic                 hit_b;
    logic                 ctc_clear;
    logic                 ev_ovf;
    logic                 ev_a;
    logic                 ev_b;
    logic [BIT_WIDTH-1:0] tcnt_next;

    assign rise = ExtEvent & ~ext_q;
    assign fall = ~ExtEvent & ext_q;

    // Select the active count source
    always_comb begin
        src = 1'b0;
        case (CounterEdge)
            SRC_TICK: src = CountTick;
            SRC_RISE: src = rise;
            SRC_FALL: src = fall;
            SRC_BOTH: src = rise | fall;
            default:  src = 1'b0;
        endcase
    end

    assign inc       = CountEnable & src;
    assign at_max    = (TCNT == MAX_COUNT);
    assign hit_a     = (TCNT == CompareA);
    assign hit_b     = (TCNT == CompareB);
    assign ctc_clear = ((ClearMode == CTC_A) & hit_a) | ((ClearMode == CTC_B) & hit_b);

    // Clear and load swallow a coincident increment, including its events
    assign count_ok = inc & ~CounterClear & ~LoadEn;
    assign ev_a     = count_ok & hit_a;
    assign ev_b     = count_ok & hit_b;
    assign ev_ovf   = count_ok & at_max & ~ctc_clear;

    // Next counter value: clear, then load, then increment (CTC, wrap/saturate)
    always_comb begin
        tcnt_next = TCNT;
        if (CounterClear) begin
            tcnt_next = '0;
        end else if (LoadEn) begin
            tcnt_next = LoadValue;
        end else if (inc) begin
            if (ctc_clear) begin
                tcnt_next = '0;
            end else if (at_max) begin
                tcnt_next = WrapMode ? '0 : MAX_COUNT;
            end else begin
                tcnt_next = TCNT + 1'b1;
            end
        end
    end

    // Edge-detect history; reset loads the live level so release makes no edge
    always_ff @(posedge CounterClock) begin
        ext_q <= ExtEvent;
    end

    // Counter register
    always_ff @(posedge CounterClock) begin
        if (CounterReset) begin
            TCNT <= '0;
        end else begin
            TCNT <= tcnt_next;
        end
    end

    // Sticky flags: a new event outranks a same-cycle clear request
    always_ff @(posedge CounterClock) begin
        if (CounterReset) begin
            Overflow <= 1'b0;
            MatchA   <= 1'b0;
            MatchB   <= 1'b0;
        end else begin
            Overflow <= ev_ovf | (Overflow & ~FlagClear[0]);
            MatchA   <= ev_a   | (MatchA   & ~FlagClear[1]);
            MatchB   <= ev_b   | (MatchB   & ~FlagClear[2]);
        end
    end

    // Interrupt strobe: one cycle per cycle with any event, independent of flags
    always_ff @(posedge CounterClock) begin
        if (CounterReset) begin
            EventPulse <= 1'b0;
        end else begin
            EventPulse <= ev_ovf | ev_a | ev_b;
        end
    end

endmodule

// File: tb/tb_timer_counter_unit.sv
// Directed self-checking bench for timer_counter_unit (BIT_WIDTH = 8).
module tb_timer_counter_unit;

    logic       clk;
    logic       rst;
    logic       count_enable;
    logic       count_tick;
    logic       ext_event;
    logic [1:0] counter_edge;
    logic       wrap_mode;
    logic [1:0] clear_mode;
    logic       counter_clear;
    logic       load_en;
    logic [7:0] load_value;
    logic [7:0] compare_a;
    logic [7:0] compare_b;
    logic [2:0] flag_clear;
    logic [7:0] tcnt;
    logic       overflow;
    logic       match_a;
    logic       match_b;
    logic       event_pulse;

    int vectors;
    int miscompares;

    timer_counter_unit #(.BIT_WIDTH(8)) dut (
        .CounterClock (clk),
        .CounterReset (rst),
        .CountEnable  (count_enable),
        .CountTick    (count_tick),
        .ExtEvent     (ext_event),
        .CounterEdge  (counter_edge),
        .WrapMode     (wrap_mode),
        .ClearMode    (clear_mode),
        .CounterClear (counter_clear),
        .LoadEn       (load_en),
        .LoadValue    (load_value),
        .CompareA     (compare_a),
        .CompareB     (compare_b),
        .FlagClear    (flag_clear),
        .TCNT         (tcnt),
        .Overflow     (overflow),
        .MatchA       (match_a),
        .MatchB       (match_b),
        .EventPulse   (event_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle 1 ns past the edge before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        count_enable  = 1'b0;
        count_tick    = 1'b0;
        ext_event     = 1'b1;
        counter_edge  = 2'b00;
        wrap_mode     = 1'b1;
        clear_mode    = 2'b00;
        counter_clear = 1'b0;
        load_en       = 1'b0;
        load_value    = 8'h00;
        compare_a     = 8'h80;
        compare_b     = 8'h81;
        flag_clear    = 3'b000;

        // Reset wins even with load requested
        load_en    = 1'b1;
        load_value = 8'h55;
        step();
        step();
        load_en = 1'b0;
        check("reset_tcnt", 32'(tcnt), 32'h0);
        check("reset_ovf", 32'(overflow), 32'h0);
        check("reset_match", 32'({match_a, match_b}), 32'h0);
        check("reset_pulse", 32'(event_pulse), 32'h0);

        // 1: rising-edge source, ExtEvent high through reset release
        rst          = 1'b0;
        count_enable = 1'b1;
        counter_edge = 2'b01;
        step();
        check("t1_no_spurious", 32'(tcnt), 32'h0);
        ext_event = 1'b0;
        step();
        check("t1_fall_ignored", 32'(tcnt), 32'h0);
        ext_event = 1'b1;
        step();
        check("t1_rise_counts", 32'(tcnt), 32'h1);
        step();
        check("t1_hold", 32'(tcnt), 32'h1);

        // 2: tick source, wrap 255 -> 0
        counter_edge = 2'b00;
        count_tick   = 1'b1;
        load_en      = 1'b1;
        load_value   = 8'hFD;
        step();
        load_en = 1'b0;
        check("t2_load", 32'(tcnt), 32'hFD);
        step();
        step();
        check("t2_at_max", 32'(tcnt), 32'hFF);
        check("t2_no_ovf_yet", 32'(overflow), 32'h0);
        step();
        check("t2_wrap", 32'(tcnt), 32'h0);
        check("t2_ovf_set", 32'(overflow), 32'h1);
        check("t2_pulse", 32'(event_pulse), 32'h1);
        step();
        check("t2_after_wrap", 32'(tcnt), 32'h1);
        check("t2_pulse_one_cycle", 32'(event_pulse), 32'h0);
        check("t2_ovf_sticky", 32'(overflow), 32'h1);
        flag_clear = 3'b001;
        step();
        flag_clear = 3'b000;
        check("t2_ovf_w1c", 32'(overflow), 32'h0);

        // 3: saturate, 300 ticks from zero
        wrap_mode     = 1'b0;
        counter_clear = 1'b1;
        step();
        counter_clear = 1'b0;
        check("t3_soft_clear", 32'(tcnt), 32'h0);
        repeat (300) step();
        check("t3_saturated", 32'(tcnt), 32'hFF);
        check("t3_ovf", 32'(overflow), 32'h1);
        check("t3_matches_passed", 32'({match_a, match_b}), 32'h3);
        check("t3_pulse_while_sat", 32'(event_pulse), 32'h1);
        flag_clear = 3'b001;
        step();
        check("t3_set_beats_clear", 32'(overflow), 32'h1);
        check("t3_still_sat", 32'(tcnt), 32'hFF);
        count_tick = 1'b0;
        step();
        flag_clear = 3'b000;
        check("t3_ovf_cleared", 32'(overflow), 32'h0);
        check("t3_pulse_idle", 32'(event_pulse), 32'h0);

        // 4: CTC on A=9, B=4 flags without clearing
        flag_clear = 3'b111;
        step();
        flag_clear    = 3'b000;
        counter_clear = 1'b1;
        step();
        counter_clear = 1'b0;
        wrap_mode     = 1'b1;
        clear_mode    = 2'b01;
        compare_a     = 8'd9;
        compare_b     = 8'd4;
        count_tick    = 1'b1;
        repeat (5) step();
        check("t4_tcnt5", 32'(tcnt), 32'd5);
        check("t4_matchb", 32'({match_a, match_b}), 32'h1);
        check("t4_pulse_b", 32'(event_pulse), 32'h1);
        repeat (4) step();
        check("t4_tcnt9", 32'(tcnt), 32'd9);
        check("t4_no_matcha_yet", 32'(match_a), 32'h0);
        step();
        check("t4_ctc_zero", 32'(tcnt), 32'd0);
        check("t4_matcha", 32'(match_a), 32'h1);
        check("t4_no_ovf", 32'(overflow), 32'h0);
        flag_clear = 3'b010;
        step();
        flag_clear = 3'b000;
        check("t4_matcha_w1c", 32'(match_a), 32'h0);
        check("t4_tcnt1", 32'(tcnt), 32'd1);
        repeat (8) step();
        flag_clear = 3'b010;
        step();
        flag_clear = 3'b000;
        check("t4_period10", 32'(tcnt), 32'd0);
        check("t4_set_beats_clear", 32'(match_a), 32'h1);

        // 5: both-edge source, then counting disabled
        count_tick = 1'b0;
        clear_mode = 2'b00;
        flag_clear = 3'b111;
        step();
        flag_clear    = 3'b000;
        counter_clear = 1'b1;
        step();
        counter_clear = 1'b0;
        counter_edge  = 2'b11;
        for (int i = 0; i < 4; i++) begin
            ext_event = ~ext_event;
            step();
        end
        check("t5_both_edges", 32'(tcnt), 32'd4);
        count_enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ext_event = ~ext_event;
            step();
        end
        check("t5_disabled", 32'(tcnt), 32'd4);

        // 6: load near max, then inc coincident with load / clear
        count_enable = 1'b1;
        counter_edge = 2'b00;
        load_en      = 1'b1;
        load_value   = 8'hFE;
        step();
        load_en = 1'b0;
        check("t6_load_fe", 32'(tcnt), 32'hFE);
        count_tick = 1'b1;
        step();
        check("t6_ff", 32'(tcnt), 32'hFF);
        load_en    = 1'b1;
        load_value = 8'h20;
        step();
        load_en = 1'b0;
        check("t6_load_beats_inc", 32'(tcnt), 32'h20);
        check("t6_load_no_ovf", 32'(overflow), 32'h0);
        load_en    = 1'b1;
        load_value = 8'hFF;
        count_tick = 1'b0;
        step();
        load_en       = 1'b0;
        count_tick    = 1'b1;
        counter_clear = 1'b1;
        step();
        counter_clear = 1'b0;
        count_tick    = 1'b0;
        check("t6_clear_beats_inc", 32'(tcnt), 32'h0);
        check("t6_clear_no_ovf", 32'(overflow), 32'h0);
        step();
        check("t6_clear_no_pulse", 32'(event_pulse), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
